// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one RegisterFile among NUM_REQ sub-controllers.
// The registered one-hot grant steers the owner's address/data/write-enable onto the file.
module regfile_access_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      we_in,
    input  logic [5*NUM_REQ-1:0]    rs1_in,
    input  logic [5*NUM_REQ-1:0]    rs2_in,
    input  logic [5*NUM_REQ-1:0]    rd_in,
    input  logic [32*NUM_REQ-1:0]   wdata_in,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [31:0]             rdata1_out,
    output logic [31:0]             rdata2_out,
    output logic [4:0]              rf_rs1,
    output logic [4:0]              rf_rs2,
    output logic [4:0]              rf_rd,
    output logic [31:0]             rf_wdata,
    output logic                    rf_we,
    input  logic [31:0]             rf_rdata1,
    input  logic [31:0]             rf_rdata2,
    output logic                    busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [NUM_REQ-1:0] others;
    logic [IDX_W-1:0]   last_owner, last_owner_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;

    // First set bit searching upward from last+1 with wrap; last itself is checked last.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                   input logic [IDX_W-1:0]   last);
        logic [NUM_REQ-1:0] pick;
        int unsigned        idx;
        pick = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last) + k) % NUM_REQ;
            if (pick == '0 && r[idx]) pick[idx] = 1'b1;
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            if (oh[i]) idx = IDX_W'(i);
        return idx;
    endfunction

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        hold_cnt_nxt   = hold_cnt;
        last_owner_nxt = last_owner;
        others         = req & ~gnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt   = rr_pick(req, last_owner);
                    state_nxt = OWN;
                end
            end
            OWN: begin
                if (!(|(req & gnt))) begin
                    gnt_nxt = rr_pick(others, last_owner);
                    if (gnt_nxt == '0) state_nxt = IDLE;
                end else if (hold_cnt == HOLD_LAST && |others) begin
                    gnt_nxt = rr_pick(others, last_owner);
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (gnt_nxt != gnt) begin
            hold_cnt_nxt = '0;
            if (|gnt_nxt) last_owner_nxt = to_idx(gnt_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            busy       <= 1'b0;
            hold_cnt   <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            busy       <= |gnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // One-hot grant lets the mux be a plain AND-OR; zero grant yields zero outputs.
    always_comb begin
        rf_rs1   = '0;
        rf_rs2   = '0;
        rf_rd    = '0;
        rf_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                rf_rs1   = rf_rs1   | rs1_in[5*i +: 5];
                rf_rs2   = rf_rs2   | rs2_in[5*i +: 5];
                rf_rd    = rf_rd    | rd_in[5*i +: 5];
                rf_wdata = rf_wdata | wdata_in[32*i +: 32];
            end
        end
    end

    // Gated by rst so a reset landing mid-grant never commits a write.
    assign rf_we      = (|(gnt & req & we_in)) & ~rst;
    assign rdata1_out = rf_rdata1;
    assign rdata2_out = rf_rdata2;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with a small combinational-read
// register file model attached to the rf_* ports.
module tb_regfile_access_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req, we_in, gnt;
    logic [19:0]  rs1_in, rs2_in, rd_in;
    logic [127:0] wdata_in;
    logic [31:0]  rdata1_out, rdata2_out, rf_wdata, rf_rdata1, rf_rdata2;
    logic [4:0]   rf_rs1, rf_rs2, rf_rd;
    logic         rf_we, busy;

    logic [31:0]  rf_mem [32];
    logic         init_mem = 1'b1;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cnt;

    regfile_access_arbiter #(.NUM_REQ(4), .MAX_HOLD(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we_in(we_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .wdata_in(wdata_in),
        .gnt(gnt), .rdata1_out(rdata1_out), .rdata2_out(rdata2_out),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .rf_we(rf_we), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .busy(busy)
    );

    always #5 clk = ~clk;

    assign rf_rdata1 = rf_mem[rf_rs1];
    assign rf_rdata2 = rf_mem[rf_rs2];

    // Register i starts at 32'h5A5A_0000 + i.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h5A5A_0000 + 32'(i);
        end else if (rf_we) begin
            rf_mem[rf_rd] <= rf_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 4'b1111; we_in = 4'b1111;
        rs1_in = '0; rs2_in = '0; rd_in = '0; wdata_in = '0;
        tick();
        init_mem = 1'b0;
        tick();
        // Reset with every requester asking
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_we", 32'(rf_we), 32'h0);
        we_in = 4'b0000;
        rst = 1'b0;
        tick();
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_rs1_zero", 32'(rf_rs1), 32'h0);

        // Lone write from requester 2
        req = 4'b0100; we_in = 4'b0100;
        rd_in[14:10] = 5'd7; rs1_in[14:10] = 5'd7; rs1_in[4:0] = 5'd3;
        wdata_in[95:64] = 32'hDEADBEEF;
        check("pre_gnt_we", 32'(rf_we), 32'h0);
        tick();
        check("w_gnt", 32'(gnt), 32'h4);
        check("w_we", 32'(rf_we), 32'h1);
        check("w_rd", 32'(rf_rd), 32'd7);
        check("w_wdata", rf_wdata, 32'hDEADBEEF);
        check("w_rs1_owner", 32'(rf_rs1), 32'd7);
        check("w_same_cycle_old", rdata1_out, 32'h5A5A0007);
        tick();
        we_in = 4'b0000;
        #1;
        check("w_readback", rdata1_out, 32'hDEADBEEF);
        req = 4'b0000; we_in = 4'b0100;
        #1;
        check("drop_no_we", 32'(rf_we), 32'h0);
        we_in = 4'b0000;
        tick();
        check("w_release", 32'(gnt), 32'h0);

        // Round robin 0,1,2,3,0 with each owner holding one cycle
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        tick(); check("rr0", 32'(gnt), 32'h1);
        req = 4'b1110;
        tick(); check("rr1", 32'(gnt), 32'h2); check("rr1_busy", 32'(busy), 32'h1);
        req = 4'b1101;
        tick(); check("rr2", 32'(gnt), 32'h4); check("rr2_busy", 32'(busy), 32'h1);
        req = 4'b1011;
        tick(); check("rr3", 32'(gnt), 32'h8); check("rr3_busy", 32'(busy), 32'h1);
        req = 4'b0111;
        tick(); check("rr0_again", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick(); check("rr_idle", 32'(gnt), 32'h0);

        // Pre-emption after MAX_HOLD owned cycles
        req = 4'b0001;
        tick();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (gnt != 4'b0001) break;
            cnt++;
            if (cnt == 2) req = 4'b0011;
            tick();
        end
        check("hold_cycles", 32'(cnt), 32'd8);
        check("preempt_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();

        // Sole requester is never pre-empted
        req = 4'b1000;
        cnt = 0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (gnt == 4'b1000) cnt++;
            tick();
        end
        check("solo_hold", 32'(cnt), 32'd20);
        req = 4'b0000;
        tick();

        // Reset landing on a write cycle
        req = 4'b0010; we_in = 4'b0010;
        rd_in[9:5] = 5'd5; rs1_in[9:5] = 5'd5; wdata_in[63:32] = 32'h12345678;
        tick();
        check("r6_gnt", 32'(gnt), 32'h2);
        rst = 1'b1;
        #1;
        check("r6_we_in_rst", 32'(rf_we), 32'h0);
        tick();
        check("r6_gnt_dropped", 32'(gnt), 32'h0);
        rst = 1'b0; we_in = 4'b0000;
        tick();
        check("r6_regrant", 32'(gnt), 32'h2);
        check("r6_reg_intact", rdata1_out, 32'h5A5A0005);
        req = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
